// File: rtl/groestl_src_fifo.sv
// ---------------------------------------------------------------------------
// groestl_src_fifo
//   Input staging buffer in front of the Groestl core source port. Two 32-bit
//   bus writes (low half, then high half) form one 64-bit message word. Either
//   half may be byte-swapped. Words are queued in a first-word-fall-through
//   FIFO and offered to the core through its active-low src_ready / src_read
//   handshake.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset of all control state
//   flush      : synchronous clear of FIFO, low-half register and sticky flags
//   wr_data    : 32-bit bus write data
//   wr_lo      : latch (optionally swapped) wr_data into the low-half register
//   wr_hi      : push {swapped-or-not wr_data, low half} into the FIFO
//   swap       : byte-swap wr_data for this wr_lo / wr_hi
//   full       : level == DEPTH
//   level      : number of stored words
//   overflow   : sticky, push attempted while full
//   underflow  : sticky, src_read attempted while empty
//   src_ready  : active-low word-available (0 = src_dout valid)
//   src_read   : core pops the head word
//   src_dout   : head word, 0 while empty
// ---------------------------------------------------------------------------
module groestl_src_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [31:0]   wr_data,
    input  logic          wr_lo,
    input  logic          wr_hi,
    input  logic          swap,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underflow,
    output logic          src_ready,
    input  logic          src_read,
    output logic [63:0]   src_dout
);

    localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

    function automatic logic [31:0] byte_swap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [31:0]   r_lo;
    logic          r_overflow;
    logic          r_underflow;

    logic [31:0]   w_d;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign w_d     = swap ? byte_swap(wr_data) : wr_data;
    assign w_full  = (r_level == LP_FULL);
    assign w_empty = (r_level == '0);

    // Full is judged on the registered level, so a pop in the same cycle does
    // not make room for a push (no write-through when full).
    assign w_push_ok = wr_hi    & ~w_full  & ~flush;
    assign w_pop_ok  = src_read & ~w_empty & ~flush;

    // Storage carries data only and is not reset; empty forces src_dout to 0.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {w_d, r_lo};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_lo        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_lo        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            // wr_hi takes priority: a simultaneous wr_lo is discarded.
            if (wr_lo && !wr_hi) begin
                r_lo <= w_d;
            end
            if (wr_hi && w_full) begin
                r_overflow <= 1'b1;
            end
            if (src_read && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign full      = w_full;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign src_ready = w_empty;
    assign src_dout  = w_empty ? 64'd0 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_groestl_src_fifo.sv
module tb_groestl_src_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] wr_data;
    logic        wr_lo;
    logic        wr_hi;
    logic        swap;
    logic        full;
    logic [4:0]  level;
    logic        overflow;
    logic        underflow;
    logic        src_ready;
    logic        src_read;
    logic [63:0] src_dout;

    always #5 clk = ~clk;

    groestl_src_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .wr_data   (wr_data),
        .wr_lo     (wr_lo),
        .wr_hi     (wr_hi),
        .swap      (swap),
        .full      (full),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow),
        .src_ready (src_ready),
        .src_read  (src_read),
        .src_dout  (src_dout)
    );

    // Reference model: a queue of words plus the low half and sticky flags.
    logic [63:0] m_q[$];
    logic [31:0] m_lo;
    logic        m_ovf;
    logic        m_unf;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = x[8*(3-i) +: 8];
        return r;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_lo  = 32'd0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Apply the inputs present just before the edge to the model.
    task automatic model_step();
        logic [31:0] d;
        bit          was_full;
        bit          was_empty;
        d = swap ? bswap(wr_data) : wr_data;
        if (flush) begin
            model_clear();
        end else begin
            was_full  = (m_q.size() == 16);
            was_empty = (m_q.size() == 0);
            if (src_read && !was_empty) void'(m_q.pop_front());
            if (wr_hi && !was_full) m_q.push_back({d, m_lo});
            if (wr_hi && was_full) m_ovf = 1'b1;
            if (src_read && was_empty) m_unf = 1'b1;
            if (wr_lo && !wr_hi) m_lo = d;
        end
    endtask

    task automatic check_all();
        chk("level", 64'(level), 64'(m_q.size()));
        chk("full", 64'(full), 64'(m_q.size() == 16));
        chk("src_ready", 64'(src_ready), 64'(m_q.size() == 0));
        chk("src_dout", src_dout, (m_q.size() != 0) ? m_q[0] : 64'd0);
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underflow", 64'(underflow), 64'(m_unf));
    endtask

    task automatic idle_inputs();
        flush = 0; wr_lo = 0; wr_hi = 0; swap = 0; src_read = 0; wr_data = 32'd0;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        idle_inputs();
    endtask

    task automatic drive(input bit lo, input bit hi, input bit sw, input bit rd,
                         input bit fl, input logic [31:0] data);
        wr_lo = lo; wr_hi = hi; swap = sw; src_read = rd; flush = fl; wr_data = data;
        cyc();
    endtask

    task automatic push_word(input logic [31:0] hi_half);
        drive(0, 1, 0, 0, 0, hi_half);
    endtask

    initial begin
        logic [31:0] lo_val;
        idle_inputs();
        model_clear();

        // Reset state
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_src_ready", 64'(src_ready), 64'd1);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_src_dout", src_dout, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        reset = 1'b0;

        // Swap and word assembly
        drive(1, 0, 1, 0, 0, 32'h03020100);
        drive(0, 1, 1, 0, 0, 32'h07060504);
        chk("swap_word", src_dout, 64'h0405060700010203);
        chk("swap_ready", 64'(src_ready), 64'd0);
        chk("swap_level", 64'(level), 64'd1);
        drive(0, 0, 0, 1, 0, 32'd0);
        chk("swap_pop_ready", 64'(src_ready), 64'd1);
        chk("swap_pop_level", 64'(level), 64'd0);

        // Fill and wrap
        drive(1, 0, 0, 0, 0, 32'hA5A5_0000);
        for (int i = 0; i < 16; i++) push_word(32'(i));
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_level", 64'(level), 64'd16);
        push_word(32'hDEAD_BEEF);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_level", 64'(level), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 64'(src_dout[63:32]), 64'(i));
            drive(0, 0, 0, 1, 0, 32'd0);
        end
        push_word(32'h100);
        for (int i = 1; i < 20; i++) drive(0, 1, 0, 1, 0, 32'h100 + 32'(i));
        drive(0, 0, 0, 1, 0, 32'd0);

        // Simultaneous push and pop at level 5
        for (int i = 0; i < 5; i++) push_word(32'h200 + 32'(i));
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 0, 32'h300 + 32'(i));
            chk("simul_level5", 64'(level), 64'd5);
        end
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 32'd0);

        // Simultaneous at level 0
        drive(0, 1, 0, 1, 0, 32'h400);
        chk("simul0_level", 64'(level), 64'd1);
        chk("simul0_underflow", 64'(underflow), 64'd1);

        // Flush with level 7 and overflow set
        for (int i = 0; i < 16; i++) push_word(32'h500 + 32'(i));
        for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, 0, 32'd0);
        chk("pre_flush_level", 64'(level), 64'd7);
        chk("pre_flush_ovf", 64'(overflow), 64'd1);
        drive(0, 1, 0, 0, 1, 32'h600);
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_ready", 64'(src_ready), 64'd1);
        chk("flush_ovf", 64'(overflow), 64'd0);
        chk("flush_dout", src_dout, 64'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 9; i++) push_word(32'h700 + 32'(i));
        chk("pre_arst_level", 64'(level), 64'd9);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_ready", 64'(src_ready), 64'd1);
        chk("arst_dout", src_dout, 64'd0);
        #1;
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        check_all();

        // Randomized traffic with shifting push/pop bias
        for (int i = 0; i < 600; i++) begin
            int push_pct;
            int pop_pct;
            push_pct = ((i / 60) % 2 == 0) ? 75 : 30;
            pop_pct  = ((i / 60) % 2 == 0) ? 30 : 75;
            lo_val = $urandom;
            drive(($urandom_range(0, 99) < 40),
                  ($urandom_range(0, 99) < push_pct),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 99) < pop_pct),
                  ($urandom_range(0, 63) == 0),
                  lo_val);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
